// File: rtl/dsp_io_bank.sv
// Converter-side sample banks swapped on frame_sync, with a DSP read/write port.
// DSP writes are saturated to converter width; errors are reported as sticky flags.
module dsp_io_bank #(
    parameter int NUM_CHANNELS = 8,
    parameter int IO_WIDTH     = 24,
    parameter int DATA_WIDTH   = 36,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_sync,
    input  logic [NUM_CHANNELS*IO_WIDTH-1:0] audio_in,
    output logic [NUM_CHANNELS*IO_WIDTH-1:0] audio_out,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [NUM_CHANNELS-1:0]          clip,
    output logic                             underrun,
    output logic                             addr_err,
    input  logic                             err_clear,
    output logic [15:0]                      frame_count
);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [ADDR_WIDTH:0]   NCH_LIM = (ADDR_WIDTH+1)'(NUM_CHANNELS);
    localparam logic [IO_WIDTH-1:0]   SAT_MAX = {1'b0, {(IO_WIDTH-1){1'b1}}};
    localparam logic [IO_WIDTH-1:0]   SAT_MIN = {1'b1, {(IO_WIDTH-1){1'b0}}};

    typedef logic [NUM_CHANNELS-1:0][IO_WIDTH-1:0] bank_t;

    bank_t                   in_bank_q, in_bank_d;
    bank_t                   out_shadow_q, out_shadow_d;
    bank_t                   audio_out_q, audio_out_d;
    logic [NUM_CHANNELS-1:0] written_q, written_d;
    logic [NUM_CHANNELS-1:0] clip_q, clip_d;
    logic                    primed_q, primed_d;
    logic                    underrun_q, underrun_d;
    logic                    addr_err_q, addr_err_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                         rd_ok, wr_ok, wr_sat_hit;
    logic [IDX_W-1:0]             rd_idx, wr_idx;
    logic [IO_WIDTH-1:0]          rd_sample, wr_sample;
    logic [DATA_WIDTH-IO_WIDTH:0] wr_upper;

    assign rd_ok     = ({1'b0, rd_addr} < NCH_LIM);
    assign wr_ok     = ({1'b0, wr_addr} < NCH_LIM);
    assign rd_idx    = rd_addr[IDX_W-1:0];
    assign wr_idx    = wr_addr[IDX_W-1:0];
    assign rd_sample = in_bank_q[rd_idx];

    // The value fits iff every bit from the IO sign bit upward agrees.
    assign wr_upper   = wr_data[DATA_WIDTH-1:IO_WIDTH-1];
    assign wr_sat_hit = !((&wr_upper) || !(|wr_upper));
    assign wr_sample  = !wr_sat_hit ? wr_data[IO_WIDTH-1:0]
                                    : (wr_data[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX);

    always_comb begin
        in_bank_d     = in_bank_q;
        out_shadow_d  = out_shadow_q;
        audio_out_d   = audio_out_q;
        written_d     = written_q;
        primed_d      = primed_q;
        frame_count_d = frame_count_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_en;
        clip_d        = err_clear ? '0 : clip_q;
        addr_err_d    = (err_clear ? 1'b0 : addr_err_q)
                        | (rd_en & ~rd_ok) | (wr_en & ~wr_ok);
        underrun_d    = (err_clear ? 1'b0 : underrun_q)
                        | (frame_sync & primed_q & ~(&written_q));

        if (rd_en) begin
            rd_data_d = rd_ok ? {{(DATA_WIDTH-IO_WIDTH){rd_sample[IO_WIDTH-1]}}, rd_sample}
                              : '0;
        end

        if (frame_sync) begin
            in_bank_d     = audio_in;
            audio_out_d   = out_shadow_q;
            written_d     = '0;
            primed_d      = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end

        // Applied after the frame swap so a coincident write lands in the fresh mask.
        if (wr_en && wr_ok) begin
            out_shadow_d[wr_idx] = wr_sample;
            written_d[wr_idx]    = 1'b1;
            if (wr_sat_hit) begin
                clip_d[wr_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_bank_q     <= '0;
            out_shadow_q  <= '0;
            audio_out_q   <= '0;
            written_q     <= '0;
            primed_q      <= 1'b0;
            frame_count_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            clip_q        <= '0;
            underrun_q    <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            in_bank_q     <= in_bank_d;
            out_shadow_q  <= out_shadow_d;
            audio_out_q   <= audio_out_d;
            written_q     <= written_d;
            primed_q      <= primed_d;
            frame_count_q <= frame_count_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            clip_q        <= clip_d;
            underrun_q    <= underrun_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign audio_out   = audio_out_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign clip        = clip_q;
    assign underrun    = underrun_q;
    assign addr_err    = addr_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/dsp_io_bank.md
DSP_IO_BANK -- requirements
Module: dsp_io_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, meaning number of audio input and number of audio output channels (1..256).
REQ-002 SHALL have parameter IO_WIDTH, default 24, meaning signed width of converter-side samples.
REQ-003 SHALL have parameter DATA_WIDTH, default 36, meaning signed width of DSP-side data (DATA_WIDTH > IO_WIDTH).
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, meaning width of DSP-side channel addresses.
REQ-005 SHALL have port clk, input, 1, meaning the only clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port frame_sync, input, 1, meaning single-cycle frame boundary strobe.
REQ-008 SHALL have port audio_in, input, NUM_CHANNELS x IO_WIDTH, meaning converter input samples, valid at frame_sync.
REQ-009 SHALL have port audio_out, output, NUM_CHANNELS x IO_WIDTH, meaning registered converter output samples.
REQ-010 SHALL have ports rd_en (input, 1), rd_addr (input, ADDR_WIDTH), rd_data (output, DATA_WIDTH) and rd_valid (output, 1), meaning the DSP read port.
REQ-011 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_WIDTH) and wr_data (input, DATA_WIDTH), meaning the DSP write port.
REQ-012 SHALL have port clip, output, NUM_CHANNELS, meaning sticky per-channel saturation flags.
REQ-013 SHALL have ports underrun (output, 1) and addr_err (output, 1), meaning sticky error flags.
REQ-014 SHALL have ports err_clear (input, 1), meaning clears clip, underrun and addr_err, and frame_count (output, 16), meaning frames seen.

Function
REQ-015 SHALL hold two banks: in_bank (NUM_CHANNELS x IO_WIDTH) and out_shadow (NUM_CHANNELS x IO_WIDTH).
REQ-016 SHALL, on a frame_sync cycle, latch audio_in into in_bank, copy out_shadow into audio_out, and increment frame_count, all in that one cycle.
REQ-017 SHALL let frame_count wrap from 0xFFFF to 0x0000.
REQ-018 SHALL register reads with 1-cycle latency: rd_en at cycle N gives rd_data and rd_valid=1 at cycle N+1, with rd_valid=0 otherwise.
REQ-019 SHALL form rd_data as in_bank[rd_addr] sign-extended to DATA_WIDTH.
REQ-020 SHALL, when a read and frame_sync occur in the same cycle, return the in_bank value from before the latch.
REQ-021 SHALL hold rd_data at its last value when rd_valid=0.
REQ-022 SHALL saturate each write to the signed IO_WIDTH range (max 2^(IO_WIDTH-1)-1, min -2^(IO_WIDTH-1)), store the result to out_shadow[wr_addr] and set written[wr_addr].
REQ-023 SHALL set clip[wr_addr] whenever a write saturates.
REQ-024 SHALL, when a write and frame_sync occur in the same cycle, copy the pre-write out_shadow to audio_out, store the write, and set the written bit in the newly cleared mask.
REQ-025 SHALL, at frame_sync, set underrun if any written bit is 0, and then clear the written mask.
REQ-026 SHALL suppress the underrun check on the first frame_sync after reset.
REQ-027 SHALL, for an address >= NUM_CHANNELS, return rd_data=0 with rd_valid=1 on reads, ignore writes, and set addr_err for either.
REQ-028 SHALL let a flag-set event override err_clear when both occur in the same cycle, leaving that flag at 1.
REQ-029 SHALL allow simultaneous reads and writes to any addresses without interaction.

Reset
REQ-030 SHALL, under reset, clear audio_out, in_bank, out_shadow, rd_data, rd_valid, clip, underrun, addr_err, frame_count and the written mask to 0.
REQ-031 SHALL give reset priority over frame_sync, rd_en and wr_en.
REQ-032 SHALL discard any read in flight when reset is asserted, so rd_valid=0 on the following cycle.

Verification
REQ-033 SHALL cover this scenario: audio_in[3]=0x800000, frame_sync, then read addr 3 -> rd_data=0xFFF800000 (36-bit), rd_valid 1 cycle after rd_en.
REQ-034 SHALL cover this scenario: write 0x000900000 to ch 2, then write 0xFFF000000 to ch 5, then frame_sync -> audio_out[2]=0x7FFFFF, audio_out[5]=0x800000, clip=0x24.
REQ-035 SHALL cover this scenario: write all channels except ch 7, then two frame_syncs -> underrun=0 after the first (post-reset) and underrun=1 after the second.
REQ-036 SHALL cover this scenario: write ch 0 = 5 in the same cycle as frame_sync -> audio_out[0] keeps the previous value, and becomes 5 at the next frame_sync.
REQ-037 SHALL cover this scenario: read addr 8 and write addr 9 with NUM_CHANNELS=8 -> rd_data=0, no out_shadow change, addr_err=1; err_clear alone then gives addr_err=0.
REQ-038 SHALL cover this scenario: 65536 frame_syncs -> frame_count=0; reset mid-read -> rd_valid=0 and all outputs 0 on the next cycle.
